// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction-decode stage of the 8-bit pipeline.
//
// Decodes the fetched 16-bit instruction, drives the register-file read
// addresses, resolves operands (forwarding from MEM and WB), detects load-use
// and producer hazards, and latches the ID/EX pipeline register.
//
// Build option: define FORWARD_EN to enable EX/MEM -> ID forwarding.  Without
// it, any pending producer in EX or MEM stalls the dependent instruction; the
// WB same-cycle bypass is kept in both builds.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   if_valid, instr       fetched instruction and its valid flag
//   if_stall              combinational: fetch must hold instr this cycle
//   flush                 discard the instruction in ID (taken branch)
//   ex_hold               execute cannot accept; freeze ID/EX
//   rf_rs, rf_rt          register-file read addresses (combinational)
//   rf_read1, rf_read2    register-file read data
//   mem_*                 EX/MEM producer info (write enable, load, dest, data)
//   wb_*                  write-back producer info
//   ex_*                  ID/EX pipeline register outputs
//   illegal_instr         one-cycle registered pulse on an illegal opcode
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               if_stall,
    input  logic               flush,
    input  logic               ex_hold,
    output logic [1:0]         rf_rs,
    output logic [1:0]         rf_rt,
    input  logic [DATA_W-1:0]  rf_read1,
    input  logic [DATA_W-1:0]  rf_read2,
    input  logic               mem_wr_en,
    input  logic               mem_is_load,
    input  logic [1:0]         mem_rd,
    input  logic [DATA_W-1:0]  mem_result,
    input  logic               wb_wr_en,
    input  logic [1:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               ex_valid,
    output logic [2:0]         ex_alu_op,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [1:0]         ex_rd,
    output logic               ex_wr_en,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               illegal_instr
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_ST   = 4'd8;
    localparam logic [2:0] ALU_ADD = 3'd0;

    // What the ID/EX register does on the next edge.
    typedef enum logic [1:0] {
        UPD_BUBBLE = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_LATCH  = 2'd2
    } upd_e;

    logic [3:0]        op;
    logic [1:0]        rd_f;
    logic [1:0]        rs_f;
    logic [1:0]        src_b;
    logic [DATA_W-1:0] imm;
    logic              dec_legal;
    logic              dec_nop;
    logic              use_a;
    logic              use_b;
    logic              b_is_imm;
    logic [2:0]        dec_alu;
    logic              dec_wr;
    logic              dec_ld;
    logic              dec_st;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              hazard;
    upd_e              upd;
    logic              next_illegal;

    // Operand value for a source register, nearest producer first.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [1:0]        src,
        input logic [DATA_W-1:0] rf_val
    );
        logic [DATA_W-1:0] val;
        val = rf_val;
        if (wb_wr_en && (wb_rd == src)) begin
            val = wb_data;
        end else begin
            val = rf_val;
        end
`ifdef FORWARD_EN
        if (mem_wr_en && !mem_is_load && (mem_rd == src)) begin
            val = mem_result;
        end else begin
            val = val;
        end
`endif
        return val;
    endfunction

    // True when a source cannot be supplied this cycle and ID must stall.
    function automatic logic blocked(input logic [1:0] src);
        logic blk;
        blk = (ex_valid && ex_mem_rd && (ex_rd == src)) ||
              (mem_wr_en && mem_is_load && (mem_rd == src));
`ifndef FORWARD_EN
        // Without MEM forwarding every in-flight producer in EX or MEM blocks.
        blk = blk || (ex_valid && ex_wr_en && (ex_rd == src)) ||
                     (mem_wr_en && (mem_rd == src));
`endif
        return blk;
    endfunction

`ifndef FORWARD_EN
    // mem_result is only consumed by the forwarding path.
    logic unused_mem_result;
    assign unused_mem_result = ^mem_result;
`endif

    // Field extraction and opcode decode.
    always_comb begin
        op        = instr[15:12];
        rd_f      = instr[11:10];
        rs_f      = instr[9:8];
        imm       = DATA_W'(instr[7:0]);
        dec_legal = 1'b1;
        dec_nop   = 1'b0;
        use_a     = 1'b0;
        use_b     = 1'b0;
        b_is_imm  = 1'b0;
        dec_alu   = ALU_ADD;
        dec_wr    = 1'b0;
        dec_ld    = 1'b0;
        dec_st    = 1'b0;
        case (op)
            OP_NOP: begin
                dec_nop = 1'b1;
            end
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                use_a   = 1'b1;
                use_b   = 1'b1;
                dec_alu = op[2:0] - 3'd1;
                dec_wr  = 1'b1;
            end
            OP_ADDI: begin
                use_a    = 1'b1;
                b_is_imm = 1'b1;
                dec_wr   = 1'b1;
            end
            OP_LD: begin
                use_a    = 1'b1;
                b_is_imm = 1'b1;
                dec_wr   = 1'b1;
                dec_ld   = 1'b1;
            end
            OP_ST: begin
                // Second source is the rd field: it carries the store data.
                use_a    = 1'b1;
                use_b    = 1'b1;
                b_is_imm = 1'b1;
                dec_st   = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        // The second read port serves rt, or the store-data register for ST.
        if (op == OP_ST) begin
            src_b = rd_f;
        end else begin
            src_b = instr[7:6];
        end
    end

    assign rf_rs = rs_f;
    assign rf_rt = src_b;

    // Operand resolution and hazard detection.
    always_comb begin
        opnd_a   = resolve(rs_f, rf_read1);
        opnd_b   = resolve(src_b, rf_read2);
        hazard   = (use_a && blocked(rs_f)) || (use_b && blocked(src_b));
        if_stall = !flush && (ex_hold || (if_valid && hazard));
    end

    // Per-edge update priority for the ID/EX register.
    always_comb begin
        next_illegal = 1'b0;
        if (flush) begin
            upd = UPD_BUBBLE;
        end else if (ex_hold) begin
            upd = UPD_HOLD;
        end else if (if_valid && hazard) begin
            upd = UPD_BUBBLE;
        end else if (!if_valid || !dec_legal || dec_nop) begin
            upd          = UPD_BUBBLE;
            next_illegal = if_valid && !dec_legal;
        end else begin
            upd = UPD_LATCH;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 3'd0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_rd         <= 2'd0;
            ex_wr_en      <= 1'b0;
            ex_mem_rd     <= 1'b0;
            ex_mem_wr     <= 1'b0;
            illegal_instr <= 1'b0;
        end else begin
            illegal_instr <= next_illegal;
            case (upd)
                UPD_LATCH: begin
                    ex_valid      <= 1'b1;
                    ex_alu_op     <= dec_alu;
                    ex_a          <= opnd_a;
                    ex_b          <= b_is_imm ? imm : opnd_b;
                    ex_store_data <= dec_st ? opnd_b : '0;
                    ex_rd         <= rd_f;
                    ex_wr_en      <= dec_wr;
                    ex_mem_rd     <= dec_ld;
                    ex_mem_wr     <= dec_st;
                end
                UPD_HOLD: begin
                    ex_valid      <= ex_valid;
                    ex_alu_op     <= ex_alu_op;
                    ex_a          <= ex_a;
                    ex_b          <= ex_b;
                    ex_store_data <= ex_store_data;
                    ex_rd         <= ex_rd;
                    ex_wr_en      <= ex_wr_en;
                    ex_mem_rd     <= ex_mem_rd;
                    ex_mem_wr     <= ex_mem_wr;
                end
                default: begin
                    ex_valid      <= 1'b0;
                    ex_alu_op     <= 3'd0;
                    ex_a          <= '0;
                    ex_b          <= '0;
                    ex_store_data <= '0;
                    ex_rd         <= 2'd0;
                    ex_wr_en      <= 1'b0;
                    ex_mem_rd     <= 1'b0;
                    ex_mem_wr     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
// A behavioural model of the ID/EX register is stepped alongside the DUT and
// every output is compared each cycle; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_valid;
    logic [15:0] instr;
    logic       if_stall;
    logic       flush;
    logic       ex_hold;
    logic [1:0] rf_rs;
    logic [1:0] rf_rt;
    logic [7:0] rf_read1;
    logic [7:0] rf_read2;
    logic       mem_wr_en;
    logic       mem_is_load;
    logic [1:0] mem_rd;
    logic [7:0] mem_result;
    logic       wb_wr_en;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       ex_valid;
    logic [2:0] ex_alu_op;
    logic [7:0] ex_a;
    logic [7:0] ex_b;
    logic [7:0] ex_store_data;
    logic [1:0] ex_rd;
    logic       ex_wr_en;
    logic       ex_mem_rd;
    logic       ex_mem_wr;
    logic       illegal_instr;

    logic [7:0] regs [4];

    int checks = 0;
    int errors = 0;

    // Model of the ID/EX register contents.
    logic       m_valid, m_wr, m_mrd, m_mwr, m_ill;
    logic [2:0] m_alu;
    logic [7:0] m_a, m_b, m_sd;
    logic [1:0] m_rd;

    always #5 clk = ~clk;

    assign rf_read1 = regs[rf_rs];
    assign rf_read2 = regs[rf_rt];

    id_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .instr(instr),
        .if_stall(if_stall), .flush(flush), .ex_hold(ex_hold),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_read1(rf_read1), .rf_read2(rf_read2),
        .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .mem_result(mem_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .illegal_instr(illegal_instr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        m_valid = 1'b0; m_wr = 1'b0; m_mrd = 1'b0; m_mwr = 1'b0; m_ill = 1'b0;
        m_alu = 3'd0; m_a = 8'd0; m_b = 8'd0; m_sd = 8'd0; m_rd = 2'd0;
    endtask

    // Value the execute stage must see for register s.
    function automatic logic [7:0] src_value(input logic [1:0] s);
`ifdef FORWARD_EN
        if (mem_wr_en && !mem_is_load && mem_rd == s) return mem_result;
`endif
        if (wb_wr_en && wb_rd == s) return wb_data;
        return regs[s];
    endfunction

    // Register s is not yet available: a load (or, without forwarding, any write) is in flight.
    function automatic logic src_blocked(input logic [1:0] s);
        logic b;
        b = (m_valid && m_mrd && m_rd == s) || (mem_wr_en && mem_is_load && mem_rd == s);
`ifndef FORWARD_EN
        b = b || (m_valid && m_wr && m_rd == s) || (mem_wr_en && mem_rd == s);
`endif
        return b;
    endfunction

    task automatic set_idle();
        if_valid = 1'b0; instr = 16'h0000; flush = 1'b0; ex_hold = 1'b0;
        mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_rd = 2'd0; mem_result = 8'd0;
        wb_wr_en = 1'b0; wb_rd = 2'd0; wb_data = 8'd0;
    endtask

    // One clock cycle: inputs already driven at the negedge; check
    // combinational outputs, predict the edge, check registered outputs.
    task automatic step();
        logic [3:0] op;
        logic [1:0] f_rd, f_rs, f_rt, f_b;
        logic       use_a, use_b, haz, exp_stall;
        logic       n_valid, n_wr, n_mrd, n_mwr, n_ill;
        logic [2:0] n_alu;
        logic [7:0] n_a, n_b, n_sd;
        logic [1:0] n_rd;
        #1;
        if (reset) clear_model();
        op   = instr[15:12];
        f_rd = instr[11:10];
        f_rs = instr[9:8];
        f_rt = instr[7:6];
        f_b  = (op == 4'd8) ? f_rd : f_rt;
        use_a = (op >= 4'd1) && (op <= 4'd8);
        use_b = ((op >= 4'd1) && (op <= 4'd5)) || (op == 4'd8);
        haz = (use_a && src_blocked(f_rs)) || (use_b && src_blocked(f_b));
        exp_stall = !flush && (ex_hold || (if_valid && haz));
        chk("if_stall", 32'(if_stall), 32'(exp_stall));
        chk("rf_rs", 32'(rf_rs), 32'(f_rs));
        chk("rf_rt", 32'(rf_rt), 32'(f_b));

        n_valid = 1'b0; n_wr = 1'b0; n_mrd = 1'b0; n_mwr = 1'b0; n_ill = 1'b0;
        n_alu = 3'd0; n_a = 8'd0; n_b = 8'd0; n_sd = 8'd0; n_rd = 2'd0;
        if (reset) begin
            n_valid = 1'b0;
        end else if (flush) begin
            n_valid = 1'b0;
        end else if (ex_hold) begin
            n_valid = m_valid; n_wr = m_wr; n_mrd = m_mrd; n_mwr = m_mwr;
            n_alu = m_alu; n_a = m_a; n_b = m_b; n_sd = m_sd; n_rd = m_rd;
        end else if (if_valid && haz) begin
            n_valid = 1'b0;
        end else if (!if_valid || op == 4'd0 || op > 4'd8) begin
            n_ill = if_valid && (op > 4'd8);
        end else begin
            n_valid = 1'b1;
            n_alu   = (op <= 4'd5) ? 3'(op - 4'd1) : 3'd0;
            n_a     = src_value(f_rs);
            n_b     = (op <= 4'd5) ? src_value(f_rt) : instr[7:0];
            n_sd    = (op == 4'd8) ? src_value(f_rd) : 8'd0;
            n_rd    = f_rd;
            n_wr    = (op <= 4'd7);
            n_mrd   = (op == 4'd7);
            n_mwr   = (op == 4'd8);
        end

        @(posedge clk);
        #1;
        m_valid = n_valid; m_wr = n_wr; m_mrd = n_mrd; m_mwr = n_mwr; m_ill = n_ill;
        m_alu = n_alu; m_a = n_a; m_b = n_b; m_sd = n_sd; m_rd = n_rd;

        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_alu_op", 32'(ex_alu_op), 32'(m_alu));
        chk("ex_wr_en", 32'(ex_wr_en), 32'(m_wr));
        chk("ex_mem_rd", 32'(ex_mem_rd), 32'(m_mrd));
        chk("ex_mem_wr", 32'(ex_mem_wr), 32'(m_mwr));
        chk("illegal_instr", 32'(illegal_instr), 32'(m_ill));
        if (m_valid) begin
            chk("ex_a", 32'(ex_a), 32'(m_a));
            chk("ex_b", 32'(ex_b), 32'(m_b));
        end
        if (m_wr) chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        if (m_mwr) chk("ex_store_data", 32'(ex_store_data), 32'(m_sd));
        @(negedge clk);
    endtask

    task automatic random_cycles(input int n);
        logic [3:0] op;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
            reset       = ($urandom_range(0, 249) == 0);
            if_valid    = ($urandom_range(0, 7) != 0);
            op          = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 8));
            instr       = {op, 12'($urandom)};
            flush       = ($urandom_range(0, 9) == 0);
            ex_hold     = ($urandom_range(0, 7) == 0);
            mem_wr_en   = ($urandom_range(0, 1) == 1);
            mem_is_load = mem_wr_en && ($urandom_range(0, 2) == 0);
            mem_rd      = 2'($urandom);
            mem_result  = 8'($urandom);
            wb_wr_en    = ($urandom_range(0, 1) == 1);
            wb_rd       = 2'($urandom);
            wb_data     = 8'($urandom);
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] r0;
        clear_model();
        set_idle();
        for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
        reset = 1'b1;
        @(negedge clk);
        step();
        chk("reset_valid", 32'(ex_valid), 32'h0);
        chk("reset_illegal", 32'(illegal_instr), 32'h0);
        reset = 1'b0;
        random_cycles(400);

        // Reset mid-operation, then ADD r2,r0,r1 with R0=3, R1=4.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_idle();
        regs[0] = 8'd3; regs[1] = 8'd4;
        if_valid = 1'b1; instr = 16'h1840;
        step();
        chk("t1_valid", 32'(ex_valid), 32'h1);
        chk("t1_alu", 32'(ex_alu_op), 32'h0);
        chk("t1_a", 32'(ex_a), 32'h3);
        chk("t1_b", 32'(ex_b), 32'h4);
        chk("t1_rd", 32'(ex_rd), 32'h2);
        chk("t1_wr", 32'(ex_wr_en), 32'h1);

`ifdef FORWARD_EN
        // MEM beats WB: ADD r3,r1,r1 with MEM r1=0x55 and WB r1=0x22.
        mem_wr_en = 1'b1; mem_rd = 2'd1; mem_result = 8'h55;
        wb_wr_en = 1'b1; wb_rd = 2'd1; wb_data = 8'h22;
        instr = 16'h1D40;
        step();
        chk("t2_a", 32'(ex_a), 32'h55);
        chk("t2_b", 32'(ex_b), 32'h55);
`endif

        // Load-use: LD r1 then SUB r2,r1,r0 -> two stalls, then WB data.
        set_idle();
        if_valid = 1'b1; instr = 16'h7400;
        step();
        chk("t3_ld", 32'(ex_mem_rd), 32'h1);
        r0 = regs[0];
        instr = 16'h2900;
        #1 chk("t3_stall1", 32'(if_stall), 32'h1);
        step();
        chk("t3_bubble1", 32'(ex_valid), 32'h0);
        mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_rd = 2'd1; mem_result = 8'h11;
        #1 chk("t3_stall2", 32'(if_stall), 32'h1);
        step();
        chk("t3_bubble2", 32'(ex_valid), 32'h0);
        mem_wr_en = 1'b0; mem_is_load = 1'b0;
        wb_wr_en = 1'b1; wb_rd = 2'd1; wb_data = 8'hA7;
        #1 chk("t3_stall3", 32'(if_stall), 32'h0);
        step();
        chk("t3_valid", 32'(ex_valid), 32'h1);
        chk("t3_alu", 32'(ex_alu_op), 32'h1);
        chk("t3_a", 32'(ex_a), 32'hA7);
        chk("t3_b", 32'(ex_b), 32'(r0));

        // ex_hold for 3 cycles with a valid ADDI, then flush beats hold.
        set_idle();
        if_valid = 1'b1; instr = 16'h6412;
        step();
        chk("t4_b", 32'(ex_b), 32'h12);
        instr = 16'h6523; ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_hold_stall", 32'(if_stall), 32'h1);
            step();
            chk("t4_hold_b", 32'(ex_b), 32'h12);
            chk("t4_hold_rd", 32'(ex_rd), 32'h1);
        end
        flush = 1'b1;
        #1 chk("t4_flush_stall", 32'(if_stall), 32'h0);
        step();
        chk("t4_flush_valid", 32'(ex_valid), 32'h0);

        // Illegal opcode 12 pulses illegal_instr for exactly one cycle.
        set_idle();
        if_valid = 1'b1; instr = 16'hC000;
        step();
        chk("t5_illegal", 32'(illegal_instr), 32'h1);
        chk("t5_valid", 32'(ex_valid), 32'h0);
        instr = 16'h0000;
        step();
        chk("t5_pulse_end", 32'(illegal_instr), 32'h0);

`ifndef FORWARD_EN
        // No forwarding: ADD r1 then ADD r2,r1,r1 -> 2 stalls, then WB data.
        set_idle();
        if_valid = 1'b1; instr = 16'h1400;
        step();
        instr = 16'h1940;
        #1 chk("t6_stall1", 32'(if_stall), 32'h1);
        step();
        mem_wr_en = 1'b1; mem_rd = 2'd1; mem_result = 8'h77;
        #1 chk("t6_stall2", 32'(if_stall), 32'h1);
        step();
        mem_wr_en = 1'b0;
        wb_wr_en = 1'b1; wb_rd = 2'd1; wb_data = 8'h3C;
        #1 chk("t6_stall3", 32'(if_stall), 32'h0);
        step();
        chk("t6_valid", 32'(ex_valid), 32'h1);
        chk("t6_a", 32'(ex_a), 32'h3C);
        chk("t6_b", 32'(ex_b), 32'h3C);
`endif

        random_cycles(1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 8-bit pipeline.
- Decodes the fetched instruction and drives the register-file read addresses.
- Resolves operands by forwarding from MEM and WB, and detects load-use hazards.
- Latches the ID/EX pipeline register that feeds the execute stage; sits between fetch and execute, beside the 4x8 register file.

Parameters:
- INSTR_W, 16, instruction width; fixed format below, only 16 supported.
- DATA_W, 8, operand width; must match register file.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_valid  in  1  instr holds a valid instruction
- instr  in  16  fetched instruction
- if_stall  out  1  combinational; fetch must hold instr this cycle
- flush  in  1  discard ID instruction (taken branch)
- ex_hold  in  1  execute stage cannot accept; freeze ID/EX
- rf_rs  out  2  register-file read address 1 (combinational)
- rf_rt  out  2  register-file read address 2 (combinational)
- rf_read1  in  8  register-file data for rf_rs
- rf_read2  in  8  register-file data for rf_rt
- mem_wr_en, mem_is_load  in  1 each  EX/MEM producer info
- mem_rd  in  2  EX/MEM destination
- mem_result  in  8  EX/MEM ALU result
- wb_wr_en  in  1  WB write this cycle
- wb_rd  in  2  WB destination
- wb_data  in  8  WB data
- ex_valid  out  1  ID/EX holds real instruction
- ex_alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- ex_a, ex_b  out  8 each  resolved operands
- ex_store_data  out  8  store data
- ex_rd  out  2  destination
- ex_wr_en, ex_mem_rd, ex_mem_wr  out  1 each  write-back, load and store controls
- illegal_instr  out  1  registered one-cycle pulse

Behaviour:
- Instruction format: op=[15:12], rd=[11:10], rs=[9:8], rt=[7:6], imm=[7:0] (zero-extended).
- Opcodes:
  - 0 NOP.
  - 1-5 ADD/SUB/AND/OR/XOR: a=R[rs], b=R[rt], wr_en=1.
  - 6 ADDI: a=R[rs], b=imm, alu_op ADD, wr_en=1.
  - 7 LD: a=R[rs], b=imm, alu_op ADD, mem_rd=1, wr_en=1.
  - 8 ST: a=R[rs], b=imm, alu_op ADD, store_data=R[rd field], mem_wr=1.
  - 9-15 illegal.
- rf_rs=instr[9:8]; rf_rt=instr[11:10] when op=ST, else instr[7:6].
- Sources used: R-type rs and rt; ADDI/LD rs; ST rs and rd-field; NOP/illegal none.
- Operand resolution per used source, highest priority first:
  - MEM forward: mem_wr_en && !mem_is_load && mem_rd==src gives mem_result.
  - WB forward: wb_wr_en && wb_rd==src gives wb_data (covers same-cycle register-file write).
  - Otherwise register-file data.
- Hazard stall when a used source matches a load producer:
  - (ex_valid && ex_mem_rd && ex_rd==src), or
  - (mem_wr_en && mem_is_load && mem_rd==src).
- Per-edge priority, highest first:
  - reset: all outputs 0 (ex_valid=0, every control 0, data 0, illegal_instr=0).
  - flush: ID/EX becomes a bubble (all controls 0, ex_valid=0); if_stall=0; flush beats ex_hold.
  - ex_hold: ID/EX holds all values; if_stall=1.
  - hazard with if_valid: bubble inserted; if_stall=1; instruction re-decoded next cycle.
  - !if_valid, NOP or illegal: bubble. Illegal with if_valid pulses illegal_instr for 1 cycle.
  - Otherwise: latch decoded instruction, ex_valid=1.
- if_stall = !flush && (ex_hold || (if_valid && hazard)).
- Latency is one cycle from an accepted instruction to ID/EX outputs.
- Back-to-back loads to the same register stall until neither EX nor MEM holds a matching load, i.e. 2 cycles.
- Reset asserted mid-stall clears everything; no pending state survives.

Optional Feature:
- FORWARD_EN defined: MEM and WB forwarding exactly as above.
- FORWARD_EN undefined: no MEM forwarding. Any used source matching (ex_valid && ex_wr_en && ex_rd), or (mem_wr_en && mem_rd), counts as a hazard and stalls. WB same-cycle bypass is kept, because the register file reads before its write lands.

Test Plan:
- Reset mid-operation, then ADD r2,r0,r1 with R0=3, R1=4 -> next cycle ex_valid=1, ex_alu_op=0, ex_a=3, ex_b=4, ex_rd=2, ex_wr_en=1.
- MEM ALU r1=0x55 while ADD r3,r1,r1 decodes and wb_rd=1 carries 0x22 -> ex_a=ex_b=0x55 (MEM beats WB).
- LD r1 in ID/EX, then SUB r2,r1,r0 arrives -> if_stall=1 for 2 cycles, two bubbles, then SUB latches with a=wb_data.
- ex_hold=1 for 3 cycles with valid ADDI -> ID/EX outputs are stable, if_stall=1; flush plus ex_hold -> bubble, if_stall=0.
- op=12 with if_valid -> illegal_instr=1 for exactly 1 cycle, ex_valid=0.
- Without FORWARD_EN: ADD r1 then ADD r2,r1,r1 -> 2 stall cycles, then operands taken from wb_data.
